// File: rtl/serial_bus_pkg.sv
// Shared serial-bus definitions: FSM states,
// control-frame field widths/offsets, default widths.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL,
    S_SKIP,
    S_WRITE,
    S_FETCH,
    S_SEND,
    S_GAP
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 12;

  // START + ID + RW + BURST
  localparam int ID_W  = 2;
  localparam int HDR_W = 1 + ID_W + 2;

  // RW / BURST bit positions above the
  // address field in the post-START word
  localparam int RW_OFS    = 1;
  localparam int BURST_OFS = 0;

  function automatic int frame_bits(
    input int aw
  );
    return HDR_W + aw;
  endfunction

endpackage

// File: rtl/slave_memory.sv
// Single-port synchronous RAM, registered read.
// Ports: clk, i_we, i_addr, i_wdata, o_rdata.
module slave_memory #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 16,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/bus_slave.sv
// Serial-bus slave: frame decode, serial write/read.
// Ports: clk, rstN, control, wrD, valid, last -> rD, ready.
module bus_slave
  import serial_bus_pkg::*;
#(
  parameter int MEMORY_DEPTH  = 4096,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH),
  parameter logic [ID_W-1:0] SLAVE_ID = 2'b01
) (
  input  logic clk,
  input  logic rstN,
  input  logic control,
  input  logic wrD,
  input  logic valid,
  input  logic last,
  output logic rD,
  output logic ready
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int FB = frame_bits(AW) - 1;
  localparam int CW = $clog2(FB + DW);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [AW-1:0]   w_addr_inc;
  logic [FB-2:0]   r_ctrl;
  logic [FB-1:0]   w_frame;
  logic [DW-1:0]   r_sh, w_wdata, w_rdata;
  logic            r_burst, r_term;
  logic            r_rd, r_ready;
  logic            w_we, w_load;
  logic            w_bit_end, w_hdr_end;

  assign w_frame   = {r_ctrl, control};
  assign w_bit_end = (r_cnt == CW'(DW - 1));
  assign w_hdr_end = (r_cnt == CW'(FB));
  assign w_addr_inc =
    (r_addr == AW'(MEMORY_DEPTH - 1)) ?
    '0 : r_addr + 1'b1;

  assign rD    = r_rd;
  assign ready = r_ready;

  slave_memory #(
    .DEPTH (MEMORY_DEPTH),
    .WIDTH (DW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_we        = 1'b0;
    w_load      = 1'b0;
    w_wdata     = {r_sh[DW-2:0], wrD};
    unique case (r_state)
      S_IDLE: begin
        if (control) begin
          w_state_nxt = S_CTRL;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_CTRL: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_hdr_end) begin
          w_addr_nxt = w_frame[AW-1:0];
          if (w_frame[FB-1 -: ID_W] != SLAVE_ID)
            w_state_nxt = S_IDLE;
          else if (w_frame[AW+RW_OFS])
            w_state_nxt = S_WRITE;
          else
            w_state_nxt = S_FETCH;
          w_cnt_nxt = '0;
        end
      end
      S_WRITE: begin
        if (valid) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_bit_end) begin
            w_we       = 1'b1;
            w_cnt_nxt  = '0;
            w_addr_nxt = w_addr_inc;
            if (last || !r_burst)
              w_state_nxt = S_IDLE;
          end
        end
      end
      S_FETCH: begin
        // count 0: RAM read in flight;
        // count 1: read data is valid
        if (r_cnt == CW'(1)) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SEND;
        end else begin
          w_cnt_nxt = CW'(1);
        end
      end
      S_SEND: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_bit_end) begin
          w_cnt_nxt  = '0;
          w_addr_nxt = w_addr_inc;
          if (!r_burst || r_term || last)
            w_state_nxt = S_IDLE;
          else
            w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // RAM already read the new address
        if (last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_SKIP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_IDLE)
      w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ctrl  <= '0;
      r_burst <= 1'b0;
      r_term  <= 1'b0;
      r_sh    <= '0;
      r_rd    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      if (r_state == S_CTRL)
        r_ctrl <= w_frame[FB-2:0];
      if (r_state == S_CTRL && w_hdr_end)
        r_burst <= w_frame[AW+BURST_OFS];
      if (w_state_nxt == S_IDLE)
        r_term <= 1'b0;
      else if (r_state == S_SEND && last)
        r_term <= 1'b1;
      if (r_state == S_WRITE && valid) begin
        r_sh <= w_wdata;
      end else if (w_load) begin
        r_sh    <= {w_rdata[DW-2:0], 1'b0};
        r_rd    <= w_rdata[DW-1];
        r_ready <= 1'b1;
      end else if (r_state == S_SEND) begin
        if (w_bit_end) begin
          r_rd    <= 1'b0;
          r_ready <= 1'b0;
        end else begin
          r_rd <= r_sh[DW-1];
          r_sh <= {r_sh[DW-2:0], 1'b0};
        end
      end
    end
  end

endmodule
